// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and default constants for the 3BC program run controller.
// Rev 1.0
`default_nettype none

package run_ctrl_pkg;

  localparam int unsigned c_PC_W_DEF       = 10;
  localparam int unsigned c_CNT_W_DEF      = 16;
  localparam int unsigned c_NUM_PROGS_DEF  = 3;
  localparam int unsigned c_PROG0_BASE_DEF = 0;
  localparam int unsigned c_PROG1_BASE_DEF = 256;
  localparam int unsigned c_PROG2_BASE_DEF = 512;
  localparam int unsigned c_MAX_CYCLES_DEF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: RUN-cycle counter with clear, enable and watchdog terminal-count flag.
// Rev 1.0
`default_nettype none

module run_cycle_ctr
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = c_CNT_W_DEF,
  parameter int unsigned MAX_CYCLES = c_MAX_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  // Compare at 32 bits so a limit beyond the counter range never matches early.
  localparam logic [31:0] c_TC = 32'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (32'(r_count) == c_TC);

endmodule

`default_nettype wire

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: sequences one program per Start handshake, gating PC load/advance and
// counting RUN cycles until Halt or watchdog timeout. Rev 1.0
`default_nettype none

module prog_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = c_NUM_PROGS_DEF,
  parameter int unsigned PC_W       = c_PC_W_DEF,
  parameter int unsigned CNT_W      = c_CNT_W_DEF,
  parameter logic [PC_W-1:0] PROG0_BASE = PC_W'(c_PROG0_BASE_DEF),
  parameter logic [PC_W-1:0] PROG1_BASE = PC_W'(c_PROG1_BASE_DEF),
  parameter logic [PC_W-1:0] PROG2_BASE = PC_W'(c_PROG2_BASE_DEF),
  parameter int unsigned MAX_CYCLES = c_MAX_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_halt,
  output logic             o_pc_load,
  output logic [PC_W-1:0]  o_pc_load_addr,
  output logic             o_pc_en,
  output logic             o_ack,
  output logic [1:0]       o_prog_idx,
  output logic [CNT_W-1:0] o_cycle_ct,
  output logic             o_timeout
);

  localparam logic [1:0] c_LAST_IDX = 2'(NUM_PROGS - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_ack;
  logic       r_timeout;
  logic [1:0] r_prog_idx;
  logic       w_pc_load;
  logic       w_pc_en;
  logic       w_tc;
  logic       w_run;
  logic       w_run_end;

  assign w_run     = (r_state == S_RUN);
  assign w_run_end = w_run && (w_next == S_DONE);

  run_cycle_ctr #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_ctr (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_clr   (r_state == S_LOAD),
    .i_en    (w_run),
    .o_count (o_cycle_ct),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_pc_load = 1'b0;
    w_pc_en   = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ARMED;
      S_ARMED: if (!i_start) w_next = S_LOAD;
      S_LOAD: begin
        w_pc_load = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        w_pc_en = ~i_halt;
        if (i_halt || w_tc) w_next = S_DONE;
      end
      S_DONE:  if (i_start) w_next = S_ARMED;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
      r_prog_idx <= 2'd0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_DONE);
      // Halt takes precedence: a timeout is only recorded when Halt is low.
      if (r_state == S_LOAD) begin
        r_timeout <= 1'b0;
      end else if (w_run && !i_halt && w_tc) begin
        r_timeout <= 1'b1;
      end
      if (w_run_end) begin
        r_prog_idx <= (r_prog_idx == c_LAST_IDX) ? 2'd0 : r_prog_idx + 2'd1;
      end
    end
  end

  always_comb begin
    case (r_prog_idx)
      2'd0:    o_pc_load_addr = PROG0_BASE;
      2'd1:    o_pc_load_addr = PROG1_BASE;
      default: o_pc_load_addr = PROG2_BASE;
    endcase
  end

  assign o_pc_load  = w_pc_load;
  assign o_pc_en    = w_pc_en;
  assign o_ack      = r_ack;
  assign o_prog_idx = r_prog_idx;
  assign o_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: doc/prog_run_ctrl.md
# prog_run_ctrl

Run controller for the 3BC processor. It sequences program execution for each Start handshake: it loads the program counter with the selected program's base address, gates PC advance while running, and counts execution cycles. It stops on the decoder's halt indication or on a watchdog timeout, then raises Ack. It sits between the testbench ports (Start/Ack) and the fetch stage, replacing the free-running PC enable.

## Interface
- NUM_PROGS, 3: number of programs in instruction ROM; program index wraps after NUM_PROGS-1
- PC_W, 10: program counter width
- CNT_W, 16: cycle counter width
- PROG0_BASE / PROG1_BASE / PROG2_BASE, 0 / 256 / 512: PC_W-bit start address of each program
- MAX_CYCLES, 16'hFFFF: watchdog limit on RUN cycles
- Clk  in  1: clock, posedge only
- Reset  in  1: synchronous, active-high reset
- Start  in  1: testbench start request, level; a program launches on its falling edge
- Halt  in  1: from control decoder, high while the current instruction is the done instruction
- PcLoad  out  1: PC loads PcLoadAddr this cycle (priority over PcEn)
- PcLoadAddr  out  PC_W: base address of the current program
- PcEn  out  1: PC may advance (sequential or branch)
- Ack  out  1: program finished, registered
- ProgIdx  out  2: index of the current or next program
- CycleCt  out  CNT_W: RUN cycles of the last or current program
- Timeout  out  1: last program ended by the watchdog, not by Halt

## Operation
- FSM states: IDLE, ARMED, LOAD, RUN, DONE.
- IDLE: Start=1 → ARMED.
- ARMED: waits while Start=1; Start=0 → LOAD.
- LOAD: one cycle. PcLoad=1, PcLoadAddr=base[ProgIdx], CycleCt←0, Timeout←0. Always → RUN.
- RUN: PcEn = ~Halt (combinational). CycleCt increments every RUN cycle, including the Halt cycle.
  - Halt=1 → DONE.
  - Else CycleCt==MAX_CYCLES-1 → DONE with Timeout←1.
- DONE: Ack=1, CycleCt holds, ProgIdx←(ProgIdx==NUM_PROGS-1 ? 0 : ProgIdx+1) on entry. Start=1 → ARMED.
- Start is ignored in LOAD and RUN; there is no abort except Reset.
- Halt is ignored outside RUN.
- Halt and watchdog in the same cycle: Halt wins, Timeout=0.
- PcLoadAddr is combinational from ProgIdx; it is valid in every state.
- CycleCt wraps modulo 2^CNT_W only if MAX_CYCLES ≥ 2^CNT_W; otherwise the watchdog fires first.

## Timing
- Reset (any state, including mid-RUN): next state IDLE. Outputs: PcLoad=0, PcEn=0, Ack=0, ProgIdx=0, CycleCt=0, Timeout=0.
- Start falls at edge N (sampled 0 in ARMED): LOAD in cycle N+1, RUN from N+2. The first instruction at the base address executes in cycle N+2.
- Halt sampled at edge M in RUN: PcEn=0 in that cycle, so the PC does not move. Ack=1 from cycle M+1.
- Ack clears the cycle after Start is sampled high in DONE.
- A minimal program (Halt at base address) gives CycleCt=1.
- Ack, Timeout, ProgIdx, CycleCt and state are registered. PcLoad, PcEn and PcLoadAddr are combinational from state/Halt/ProgIdx.

## Structure
- Package run_ctrl_pkg: state enum (IDLE, ARMED, LOAD, RUN, DONE), PC_W/CNT_W defaults, default base-address constants.
- One sub-module, run_cycle_ctr: CNT_W counter with clear, enable, and terminal-count compare against MAX_CYCLES-1.
- The FSM and base-address mux live in prog_run_ctrl.
- TopLevel wiring:
  - PcLoad/PcLoadAddr drive the PC load path.
  - PcEn replaces the current PC enable source.
  - Halt comes from Ctrl.
  - Ack replaces the decoder Ack at the top-level port.

## Test plan
- Reset then Start high 3 cycles, low; Halt at cycle 5 of RUN → PcLoad one cycle with addr 0; Ack=1 the cycle after Halt; CycleCt=5; ProgIdx=1; Timeout=0.
- Three consecutive Start/Halt runs → PcLoadAddr 0, 256, 512; ProgIdx sequence 1, 2, 0 (wrap); Ack drops each time Start rises.
- MAX_CYCLES=20, Halt never asserted → DONE after 20 RUN cycles; CycleCt=20; Timeout=1; next run clears Timeout in LOAD.
- Halt asserted on the exact watchdog cycle → Timeout=0, Ack=1.
- Start pulsed during RUN → no PcLoad, CycleCt keeps counting, run completes normally.
- Reset asserted mid-RUN (CycleCt=7, ProgIdx=1) → next cycle IDLE with all outputs 0; a following Start loads base 0.
